// File: rtl/puf_tx_pkg.sv
// Shared types and constants for the PUF response UART transmitter.
package puf_tx_pkg;

    localparam int NUM_BYTES     = 16;
    localparam int BITS_PER_BYTE = 8;
    localparam int RESP_W        = 128;

    // Bit-level frame phases; ST_DONE is the terminal phase of a whole sequence.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Sequence-level phases tracked by the top; per-bit phases live in uart_tx_byte.
    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_SEND = 2'd1,
        SEQ_DONE = 2'd2
    } seq_e;

    // Byte 0 is the most significant byte of the response.
    function automatic logic [BITS_PER_BYTE-1:0] resp_byte(
        input logic [RESP_W-1:0] resp,
        input logic [3:0]        idx
    );
        logic [RESP_W-1:0] shifted;
        shifted = resp << {idx, 3'b000};
        return shifted[RESP_W-1 -: BITS_PER_BYTE];
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// One 8N1 UART byte: start bit, 8 data bits LSB first, stop bit.
// A load in the final stop cycle chains the next byte with no idle gap.
module uart_tx_byte
    import puf_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data,
    output logic       tx,
    output logic       byte_done
);

    localparam logic [15:0] BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  LAST_BIT    = 3'(BITS_PER_BYTE - 1);

    state_e      state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        bit_end;

    assign bit_end = (baud_q == 16'd0);
    assign tx      = tx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            baud_q  <= 16'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        baud_d    = bit_end ? BAUD_RELOAD : baud_q - 16'd1;
        bit_d     = bit_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        byte_done = 1'b0;

        case (state_q)
            ST_IDLE: begin
                baud_d = baud_q;
                tx_d   = 1'b1;
                if (load) begin
                    state_d = ST_START;
                    baud_d  = BAUD_RELOAD;
                    shift_d = data;
                    tx_d    = 1'b0;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_q == LAST_BIT) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    byte_done = 1'b1;
                    if (load) begin
                        state_d = ST_START;
                        shift_d = data;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        baud_d  = 16'd0;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                baud_d  = 16'd0;
                tx_d    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/puf_resp_uart_tx.sv
// Streams a latched 128-bit PUF response as 16 UART 8N1 bytes, once per puf_done rising edge.
// Define PUF_TX_CHECKSUM_EN to append a 17th byte holding the XOR of the response bytes.
module puf_resp_uart_tx
    import puf_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [RESP_W-1:0]  puf_out,
    input  logic               puf_done,
    output logic               tx,
    output logic               busy,
    output logic               frame_done,
    output logic [4:0]         byte_idx
);

`ifdef PUF_TX_CHECKSUM_EN
    localparam logic [4:0] LAST_IDX = 5'(NUM_BYTES);
`else
    localparam logic [4:0] LAST_IDX = 5'(NUM_BYTES - 1);
`endif

    seq_e              seq_q, seq_d;
    logic              puf_done_q;
    logic [RESP_W-1:0] hold_q, hold_d;
    logic [4:0]        idx_q, idx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              trigger;
    logic              last_byte;
    logic              load;
    logic              byte_done;
    logic [7:0]        load_byte;
    logic [7:0]        nxt_byte;
    logic [7:0]        first_byte;

`ifdef PUF_TX_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;
    logic [4:0] nxt_idx;

    // Slot NUM_BYTES carries the running XOR instead of a response byte.
    assign nxt_idx  = idx_q + 5'd1;
    assign nxt_byte = (nxt_idx == 5'(NUM_BYTES)) ? csum_q : resp_byte(hold_q, nxt_idx[3:0]);
`else
    assign nxt_byte = resp_byte(hold_q, idx_q[3:0] + 4'd1);
`endif

    assign first_byte = resp_byte(puf_out, 4'd0);
    assign trigger    = puf_done & ~puf_done_q & (seq_q == SEQ_IDLE);
    assign last_byte  = (idx_q == LAST_IDX);

    assign busy       = busy_q;
    assign frame_done = done_q;
    assign byte_idx   = idx_q;

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .data     (load_byte),
        .tx       (tx),
        .byte_done(byte_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            seq_q      <= SEQ_IDLE;
            puf_done_q <= 1'b0;
            hold_q     <= '0;
            idx_q      <= 5'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef PUF_TX_CHECKSUM_EN
            csum_q     <= 8'd0;
`endif
        end else begin
            seq_q      <= seq_d;
            puf_done_q <= puf_done;
            hold_q     <= hold_d;
            idx_q      <= idx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef PUF_TX_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    always_comb begin
        seq_d     = seq_q;
        hold_d    = hold_q;
        idx_d     = idx_q;
        busy_d    = busy_q;
        done_d    = done_q;
        load      = 1'b0;
        load_byte = nxt_byte;
`ifdef PUF_TX_CHECKSUM_EN
        csum_d    = csum_q;
`endif

        case (seq_q)
            SEQ_IDLE: begin
                // Byte 0 is taken straight from puf_out so its start bit follows the trigger by one cycle.
                if (trigger) begin
                    seq_d     = SEQ_SEND;
                    hold_d    = puf_out;
                    idx_d     = 5'd0;
                    busy_d    = 1'b1;
                    load      = 1'b1;
                    load_byte = first_byte;
`ifdef PUF_TX_CHECKSUM_EN
                    csum_d    = first_byte;
`endif
                end
            end
            SEQ_SEND: begin
                if (byte_done) begin
                    if (last_byte) begin
                        seq_d  = SEQ_DONE;
                        busy_d = 1'b0;
                        done_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 5'd1;
                        load  = 1'b1;
`ifdef PUF_TX_CHECKSUM_EN
                        csum_d = csum_q ^ nxt_byte;
`endif
                    end
                end
            end
            SEQ_DONE: begin
                if (!puf_done) begin
                    seq_d  = SEQ_IDLE;
                    done_d = 1'b0;
                end
            end
            default: begin
                seq_d  = SEQ_IDLE;
                busy_d = 1'b0;
                done_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_puf_resp_uart_tx.sv
// Bench for puf_resp_uart_tx: timeline model of the serial line plus a UART decoder for literal byte checks.
module tb_puf_resp_uart_tx;

    localparam int C = 4;
`ifdef PUF_TX_CHECKSUM_EN
    localparam int NB      = 17;
    localparam int EXP_DUR = 680;
`else
    localparam int NB      = 16;
    localparam int EXP_DUR = 640;
`endif
    localparam int SEQ_CYC = NB * 10 * C;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         puf_done = 1'b0;
    logic [127:0] puf_out = '0;
    logic         tx;
    logic         busy;
    logic         frame_done;
    logic [4:0]   byte_idx;

    puf_resp_uart_tx #(.CLKS_PER_BIT(C)) dut (
        .clk       (clk),
        .rst       (rst),
        .puf_out   (puf_out),
        .puf_done  (puf_done),
        .tx        (tx),
        .busy      (busy),
        .frame_done(frame_done),
        .byte_idx  (byte_idx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Model: a transmission is a flat timeline of NB*10*C cycles starting the cycle after the edge.
    int         m_phase = -1;
    logic       m_pd = 1'b0;
    int         m_k = 0;
    logic       m_idx_known = 1'b0;
    logic [7:0] m_bytes [17];

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_phase     = 0;
                m_pd        = 1'b0;
                m_idx_known = 1'b1;
            end else if (m_phase >= 0) begin
                case (m_phase)
                    0: if (puf_done && !m_pd) begin
                        m_bytes[16] = 8'h00;
                        for (int j = 0; j < 16; j++) begin
                            m_bytes[j]  = puf_out[127 - 8*j -: 8];
                            m_bytes[16] = m_bytes[16] ^ m_bytes[j];
                        end
                        m_phase = 1;
                        m_k     = 0;
                    end
                    1: begin
                        m_k++;
                        if (m_k == SEQ_CYC) begin
                            m_phase     = 2;
                            m_idx_known = 1'b0;
                        end
                    end
                    default: if (!puf_done) m_phase = 0;
                endcase
                m_pd = puf_done;
            end
            #1;
            if (m_phase == 1) begin
                int   j;
                int   b;
                logic e_tx;
                j = m_k / (10 * C);
                b = (m_k % (10 * C)) / C;
                if (b == 0)      e_tx = 1'b0;
                else if (b == 9) e_tx = 1'b1;
                else             e_tx = m_bytes[j][b-1];
                chk("line_tx", 32'(tx), 32'(e_tx));
                chk("line_busy", 32'(busy), 1);
                chk("line_frame_done", 32'(frame_done), 0);
                chk("line_byte_idx", 32'(byte_idx), j);
            end else if (m_phase == 2) begin
                chk("done_tx", 32'(tx), 1);
                chk("done_busy", 32'(busy), 0);
                chk("done_frame_done", 32'(frame_done), 1);
            end else if (m_phase == 0) begin
                chk("idle_tx", 32'(tx), 1);
                chk("idle_busy", 32'(busy), 0);
                chk("idle_frame_done", 32'(frame_done), 0);
                if (m_idx_known) chk("idle_byte_idx", 32'(byte_idx), 0);
            end
        end
    end

    // UART receiver sampling mid-bit, plus frame_done timing monitor.
    logic [7:0] rx_q [$];
    int         first_start_cyc = -1;
    int         fd_rise_cyc = -1;
    int         fd_high_cnt = 0;

    initial begin
        logic       rx_on;
        int         rx_off;
        logic [7:0] rx_byte;
        logic       fd_prev;
        rx_on   = 1'b0;
        rx_off  = 0;
        rx_byte = 8'h00;
        fd_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (frame_done === 1'b1) begin
                fd_high_cnt++;
                if (!fd_prev) fd_rise_cyc = cyc;
            end
            fd_prev = (frame_done === 1'b1);
            if (rst) begin
                rx_on = 1'b0;
            end else if (!rx_on) begin
                if (tx === 1'b0) begin
                    rx_on   = 1'b1;
                    rx_off  = 0;
                    rx_byte = 8'h00;
                    if (first_start_cyc < 0) first_start_cyc = cyc;
                end
            end else begin
                rx_off++;
                if (rx_off >= C && rx_off < 9*C && (rx_off % C) == C/2)
                    rx_byte[rx_off/C - 1] = tx;
                if (rx_off == 9*C + C/2) begin
                    chk("rx_stop_bit", 32'(tx), 1);
                    rx_q.push_back(rx_byte);
                end
                if (rx_off == 10*C - 1) rx_on = 1'b0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_rx();
        rx_q.delete();
        first_start_cyc = -1;
        fd_rise_cyc     = -1;
        fd_high_cnt     = 0;
    endtask

    task automatic wait_fd(input string name, input int bound);
        int i;
        i = 0;
        while (i < bound && frame_done !== 1'b1) begin
            @(negedge clk);
            i++;
        end
        chk(name, 32'(frame_done), 1);
    endtask

    task automatic check_bytes(input string name, input logic [7:0] e [$]);
        chk({name, "_count"}, rx_q.size(), e.size());
        for (int i = 0; i < e.size() && i < rx_q.size(); i++)
            chk({name, "_byte"}, 32'(rx_q[i]), 32'(e[i]));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, required under 200000", cyc);
        $fatal(1);
    end

    initial begin
        logic [7:0] e [$];
        string      s;
        logic [7:0] x;

        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(1);
        chk("reset_tx", 32'(tx), 1);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_frame_done", 32'(frame_done), 0);
        chk("reset_byte_idx", 32'(byte_idx), 0);

        // Incrementing bytes, latency and total duration.
        clear_rx();
        puf_out  = 128'h000102030405060708090A0B0C0D0E0F;
        puf_done = 1'b1;
        wait_fd("t1_frame_done", SEQ_CYC + 20);
        e = {};
        for (int i = 0; i < 16; i++) e.push_back(8'(i));
`ifdef PUF_TX_CHECKSUM_EN
        e.push_back(8'h00);
`endif
        tick(1);
        check_bytes("t1", e);
        chk("t1_duration", fd_rise_cyc - first_start_cyc, EXP_DUR);
        puf_done = 1'b0;
        tick(2);
        chk("t1_fd_clear", 32'(frame_done), 0);

        // ASCII payload; puf_out changes after the trigger must not leak into the line.
        clear_rx();
        puf_out  = 128'h5468697349734E6F74576F726B696E67;
        puf_done = 1'b1;
        tick(5);
        puf_out  = 128'hDEADBEEFCAFEF00D0123456789ABCDEF;
        wait_fd("t2_frame_done", SEQ_CYC + 20);
        s = "ThisIsNotWorking";
        e = {};
        x = 8'h00;
        for (int i = 0; i < 16; i++) begin
            e.push_back(s[i]);
            x = x ^ s[i];
        end
`ifdef PUF_TX_CHECKSUM_EN
        e.push_back(x);
`endif
        tick(1);
        check_bytes("t2", e);
        chk("t2_first_T", 32'(rx_q.size() > 0 ? rx_q[0] : 8'h00), 32'h54);
        puf_done = 1'b0;
        tick(2);

        // Held puf_done gives exactly one transmission, then re-arm with 128'h01.
        clear_rx();
        puf_out  = 128'hA5A5_5A5A_0F0F_F0F0_1234_5678_9ABC_DEF0;
        puf_done = 1'b1;
        tick(2000);
        chk("t3_single_count", rx_q.size(), NB);
        chk("t3_fd_held", 32'(frame_done), 1);
        puf_done = 1'b0;
        tick(1);
        chk("t3_fd_clear", 32'(frame_done), 0);
        tick(2);
        clear_rx();
        puf_out  = 128'h01;
        puf_done = 1'b1;
        wait_fd("t3b_frame_done", SEQ_CYC + 20);
        e = {};
        for (int i = 0; i < 15; i++) e.push_back(8'h00);
        e.push_back(8'h01);
`ifdef PUF_TX_CHECKSUM_EN
        e.push_back(8'h01);
`endif
        tick(1);
        check_bytes("t3b", e);
        chk("t3b_duration", fd_rise_cyc - first_start_cyc, EXP_DUR);
        puf_done = 1'b0;
        tick(2);

        // Reset during byte 5's data bits.
        clear_rx();
        puf_out  = 128'hFFEEDDCCBBAA99887766554433221100;
        puf_done = 1'b1;
        tick(1 + 5*10*C + 2*C);
        chk("t4_idx_before", 32'(byte_idx), 5);
        chk("t4_busy_before", 32'(busy), 1);
        rst      = 1'b1;
        puf_done = 1'b0;
        tick(1);
        chk("t4_rst_tx", 32'(tx), 1);
        chk("t4_rst_busy", 32'(busy), 0);
        chk("t4_rst_idx", 32'(byte_idx), 0);
        rst = 1'b0;
        clear_rx();
        tick(100);
        chk("t4_quiet_bytes", rx_q.size(), 0);
        chk("t4_quiet_busy", 32'(busy), 0);

        // puf_done already high when reset releases: an edge is seen.
        rst      = 1'b1;
        puf_done = 1'b1;
        puf_out  = 128'h8000000000000000000000000000007E;
        tick(2);
        rst = 1'b0;
        clear_rx();
        wait_fd("t7_frame_done", SEQ_CYC + 20);
        e = {};
        e.push_back(8'h80);
        for (int i = 0; i < 14; i++) e.push_back(8'h00);
        e.push_back(8'h7E);
`ifdef PUF_TX_CHECKSUM_EN
        e.push_back(8'hFE);
`endif
        tick(1);
        check_bytes("t7", e);
        puf_done = 1'b0;
        tick(2);

        // Toggling puf_done while busy: no effect, DONE exits at once since puf_done is low.
        clear_rx();
        puf_out  = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
        puf_done = 1'b1;
        tick(100);
        puf_done = 1'b0;
        tick(50);
        puf_done = 1'b1;
        tick(50);
        puf_done = 1'b0;
        wait_fd("t6_frame_done", SEQ_CYC + 20);
        tick(3);
        chk("t6_fd_one_cycle", fd_high_cnt, 1);
        chk("t6_fd_clear", 32'(frame_done), 0);
        tick(100);
        e = {};
        x = 8'h00;
        for (int i = 0; i < 16; i++) begin
            e.push_back(puf_out[127 - 8*i -: 8]);
            x = x ^ puf_out[127 - 8*i -: 8];
        end
`ifdef PUF_TX_CHECKSUM_EN
        e.push_back(x);
`endif
        check_bytes("t6", e);
        chk("t6_first_literal", 32'(rx_q.size() > 0 ? rx_q[0] : 8'h00), 32'h0F);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
